game_sequencer: RTL



---
 rtl/game_pkg.sv | 19 +
 rtl/bcd_counter4.sv | 44 ++++
 rtl/game_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the dino game sequencer: state encodings, score layout
// and the hit-blink period.
package game_pkg;

    localparam int BCD_W        = 4;
    localparam int SCORE_W      = 16;
    localparam int SCORE_DIGITS = SCORE_W / BCD_W;
    localparam int FLASH_PERIOD = 8;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_INTRO = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_HIT   = 3'd4,
        ST_OVER  = 3'd5
    } state_t;

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear, saturating at 9999.
// count_next exposes the value the counter will take at the next edge.
module bcd_counter4
    import game_pkg::*;
(
    input  logic               clk,
    input  logic               clear,
    input  logic               inc,
    output logic [SCORE_W-1:0] count,
    output logic [SCORE_W-1:0] count_next,
    output logic               max
);

    localparam logic [SCORE_W-1:0] COUNT_MAX = 16'h9999;

    assign max = (count == COUNT_MAX);

    always_comb begin
        logic carry;
        // NOTE: defaults first so every path assigns every output; no latches.
        count_next = count;
        carry      = inc && !max;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            if (carry) begin
                if (count[i*BCD_W +: BCD_W] == 4'd9) begin
                    count_next[i*BCD_W +: BCD_W] = '0;
                end else begin
                    count_next[i*BCD_W +: BCD_W] = count[i*BCD_W +: BCD_W] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    // NOTE: non-blocking assignments for all registered state.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Game-level sequencer for the VGA dino game: mode FSM, BCD score, best score,
// lives and the hit/over timers. Runs entirely on the pixel clock.
module game_sequencer
    import game_pkg::*;
#(
    parameter int LIVES      = 3,
    parameter int HIT_FRAMES = 60,
    parameter int OVER_SECS  = 3
) (
    input  logic        clk_65M,
    input  logic        clear,
    input  logic        game_on,
    input  logic        game_startd,
    input  logic        pause,
    input  logic        clk_1H,
    input  logic        frame_end,
    input  logic        collision,
    output logic [2:0]  mode,
    output logic        play_en,
    output logic        hit_flash,
    output logic [1:0]  lives,
    output logic [15:0] score_bcd,
    output logic [15:0] best_bcd,
    output logic        new_best
);

    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam logic [7:0] HIT_LAST   = 8'(HIT_FRAMES - 1);
    localparam logic [3:0] OVER_LIMIT = 4'(OVER_SECS);
    localparam logic [7:0] FLASH_LEN  = 8'(FLASH_PERIOD);

    state_t             state;
    state_t             state_next;
    logic [2:0]         sec_sync;
    logic               start_prev;
    logic               start_rise;
    logic [7:0]         frame_cnt;
    logic [3:0]         sec_cnt;
    logic [SCORE_W-1:0] score_next;
    logic               score_max;
    logic               sec_rise;
    logic               score_inc;
    logic               play_hit;
    logic               hit_done;
    logic               frame_wrap;
    logic               enter_play;
    logic               enter_hit;
    logic               enter_over;
    logic               enter_intro;

    // clk_1H is foreign: bits 0 and 1 resynchronise it, bit 2 holds the prior level.
    always_ff @(posedge clk_65M) begin
        if (clear) begin
            sec_sync   <= '0;
            start_prev <= 1'b0;
            start_rise <= 1'b0;
        end else begin
            sec_sync   <= {sec_sync[1:0], clk_1H};
            start_prev <= game_startd;
            start_rise <= game_startd && !start_prev;
        end
    end

    assign sec_rise   = sec_sync[1] && !sec_sync[2];
    assign play_hit   = game_on && (state == ST_PLAY) && collision;
    assign hit_done   = frame_end && (frame_cnt == HIT_LAST);
    assign frame_wrap = ((frame_cnt + 8'd1) % FLASH_LEN) == 8'd0;

    always_comb begin
        state_next = state;
        case (state)
            ST_OFF:   if (game_on) state_next = ST_INTRO;
            ST_INTRO: if (start_rise) state_next = ST_PLAY;
            ST_PLAY: begin
                if (collision) begin
                    state_next = (lives <= 2'd1) ? ST_OVER : ST_HIT;
                end else if (pause) begin
                    state_next = ST_PAUSE;
                end
            end
            ST_PAUSE: if (!pause) state_next = ST_PLAY;
            ST_HIT:   if (hit_done) state_next = pause ? ST_PAUSE : ST_PLAY;
            ST_OVER:  if (start_rise && sec_cnt == OVER_LIMIT) state_next = ST_INTRO;
            default:  state_next = ST_OFF;
        endcase
        if (!game_on) begin
            state_next = ST_OFF;
        end
    end

    assign enter_play  = (state == ST_INTRO) && (state_next == ST_PLAY);
    assign enter_hit   = (state != ST_HIT)   && (state_next == ST_HIT);
    assign enter_over  = (state != ST_OVER)  && (state_next == ST_OVER);
    assign enter_intro = (state != ST_INTRO) && (state_next == ST_INTRO);
    assign score_inc   = game_on && (state == ST_PLAY) && sec_rise && !score_max;

    bcd_counter4 u_score (
        .clk        (clk_65M),
        .clear      (clear || enter_play),
        .inc        (score_inc),
        .count      (score_bcd),
        .count_next (score_next),
        .max        (score_max)
    );

    always_ff @(posedge clk_65M) begin
        if (clear) begin
            state <= ST_OFF;
        end else begin
            state <= state_next;
        end
    end

    assign mode = state;

    always_ff @(posedge clk_65M) begin
        if (clear) begin
            play_en   <= 1'b0;
            hit_flash <= 1'b0;
            frame_cnt <= '0;
            sec_cnt   <= '0;
            lives     <= '0;
            best_bcd  <= '0;
            new_best  <= 1'b0;
        end else begin
            play_en <= (state_next == ST_PLAY);

            if (state_next != ST_HIT) begin
                hit_flash <= 1'b0;
            end else if (enter_hit) begin
                hit_flash <= 1'b1;
            end else if (frame_end && frame_wrap) begin
                hit_flash <= !hit_flash;
            end

            // Held at zero outside HIT, so a frame_end on the entry cycle is not counted.
            if (state != ST_HIT) begin
                frame_cnt <= '0;
            end else if (frame_end) begin
                frame_cnt <= frame_cnt + 8'd1;
            end

            if (state != ST_OVER) begin
                sec_cnt <= '0;
            end else if (sec_rise && sec_cnt != OVER_LIMIT) begin
                sec_cnt <= sec_cnt + 4'd1;
            end

            if (enter_play) begin
                lives <= LIVES_INIT;
            end else if (play_hit && lives != 2'd0) begin
                lives <= lives - 2'd1;
            end

            // score_next already includes a tick landing on the fatal-collision cycle.
            if (enter_over && score_next > best_bcd) begin
                best_bcd <= score_next;
                new_best <= 1'b1;
            end else if (enter_intro || enter_play) begin
                new_best <= 1'b0;
            end
        end
    end

endmodule
